// File: rtl/data_mem_bridge.sv
// MEM-stage load/store to word-aligned req/gnt/rvalid bus bridge with lane steering and load formatting.
// Latency: 1 cycle misaligned, 3+ cycles aligned (busy stalls the pipeline); waits on bus_gnt, aborts WAIT after TIMEOUT_CYCLES.
module data_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [2:0]  format,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        misaligned,
  output logic        bus_error,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  logic [2:0]  fmt_q, fmt_d;
  logic [1:0]  off_q, off_d;

  logic        access;
  logic        is_byte, is_half, mis_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  // Request decode straight from the MEM-stage inputs; 011/110/111 fall into the word case.
  always_comb begin
    access  = read_enable | write_enable;
    is_byte = (format[1:0] == 2'b00);
    is_half = (format[1:0] == 2'b01);
    mis_in  = (is_half & address[0]) | (~is_byte & ~is_half & (address[1:0] != 2'b00));
    if (is_byte) begin
      be_in    = 4'b0001 << address[1:0];
      wdata_in = {4{write_data[7:0]}};
    end else if (is_half) begin
      be_in    = address[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{write_data[15:0]}};
    end else begin
      be_in    = 4'b1111;
      wdata_in = write_data;
    end
  end

  // Load lane extraction uses the offset/format captured at request time.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (fmt_q[1:0])
      2'b00:   ld_fmt = {{24{~fmt_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{16{~fmt_q[2] & ld_half[15]}}, ld_half};
      default: ld_fmt = bus_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      fmt_q   <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      fmt_q   <= fmt_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access) state_d = mis_in ? ST_DONE : ST_REQ;
      ST_REQ:  if (bus_gnt) state_d = ST_WAIT;
      ST_WAIT: if (bus_rvalid || (cnt_q == CNT_LAST)) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    bus_req = 1'b0;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    err_d   = err_q;
    fmt_d   = fmt_q;
    off_d   = off_q;
    case (state_q)
      ST_IDLE: begin
        busy = access;
        if (access) begin
          if (mis_in) begin
            mis_d   = 1'b1;
            rdata_d = '0;
          end else begin
            addr_d  = {address[31:2], 2'b00};
            we_d    = write_enable;
            be_d    = be_in;
            wdata_d = wdata_in;
            fmt_d   = format;
            off_d   = address[1:0];
          end
        end
      end
      ST_REQ: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        if (bus_gnt) cnt_d = '0;
      end
      ST_WAIT: begin
        busy = 1'b1;
        // rvalid doubles as the write ack, so stores capture zero.
        if (bus_rvalid) begin
          rdata_d = we_q ? 32'd0 : ld_fmt;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        mis_d = 1'b0;
        err_d = 1'b0;
      end
    endcase
  end

  assign read_data  = rdata_q;
  assign misaligned = mis_q;
  assign bus_error  = err_q;
  assign bus_addr   = addr_q;
  assign bus_we     = we_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: directed cases plus random loads/stores against a byte-lane reference model,
// with a negedge monitor draining completion and bus-request scoreboards.
module tb_data_mem_bridge;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        read_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [2:0]  format = '0;
  logic [31:0] read_data;
  logic        busy, misaligned, bus_error, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  data_mem_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .address(address), .write_data(write_data),
    .read_enable(read_enable), .write_enable(write_enable), .format(format),
    .read_data(read_data), .busy(busy), .misaligned(misaligned), .bus_error(bus_error),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        err;
    int          busy;
  } cexp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          req;
  } bexp_t;

  cexp_t exp_q[$];
  bexp_t bexp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  logic  end_req = 1'b0;
  logic  end_ack = 1'b0;

  // Access size in bytes: B/BU=1, H/HU=2, everything else a word.
  function automatic int fsize(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] f, input int off, input logic [31:0] rdat);
    int          sz;
    logic [63:0] v, mask;
    sz   = fsize(f);
    v    = {32'd0, rdat} >> (8 * off);
    mask = (64'd1 << (8 * sz)) - 64'd1;
    if (sz < 4) begin
      v = v & mask;
      if (!f[2] && v[8 * sz - 1]) v = v | ~mask;
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] be_model(input int sz, input int off);
    logic [3:0] be;
    be = '0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] wdata_model(input int sz, input logic [31:0] wd);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[8 * i +: 8] = wd[8 * (i % sz) +: 8];
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Enter at #1 after a posedge with the DUT in IDLE; leave the same way after DONE.
  task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic re, input logic we,
                           input logic [2:0] f, input int gd, input int rv, input logic [31:0] rdat);
    cexp_t c;
    bexp_t b;
    int    sz, off;
    bit    mis;
    sz     = fsize(f);
    off    = int'(a[1:0]);
    mis    = (off % sz) != 0;
    c.mis  = mis;
    c.err  = !mis && (rv >= T);
    c.rd   = (mis || we || c.err) ? 32'd0 : load_model(f, off, rdat);
    c.busy = mis ? 1 : 1 + (gd + 1) + ((rv < T) ? rv + 1 : T);
    exp_q.push_back(c);
    if (!mis) begin
      b.addr  = {a[31:2], 2'b00};
      b.we    = we;
      b.be    = be_model(sz, off);
      b.wdata = (sz == 4) ? wd : wdata_model(sz, wd);
      b.req   = gd + 1;
      bexp_q.push_back(b);
    end
    address = a; write_data = wd; read_enable = re; write_enable = we; format = f;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(posedge clock) #1;
    if (!mis) begin
      repeat (gd) begin
        bus_rvalid = 1'($urandom_range(0, 1));
        bus_rdata  = $urandom;
        @(posedge clock) #1;
      end
      bus_gnt = 1'b1;
      bus_rvalid = 1'($urandom_range(0, 1));
      @(posedge clock) #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      repeat ((rv < T) ? rv : T) begin
        bus_gnt = 1'($urandom_range(0, 1));
        @(posedge clock) #1;
      end
      bus_gnt = 1'b0;
      if (rv < T) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rdat;
        @(posedge clock) #1;
        bus_rvalid = 1'b0;
      end
    end
    read_enable = 1'b0; write_enable = 1'b0;
    @(posedge clock) #1;
  endtask

  task automatic idle_noise(input int n);
    repeat (n) begin
      address = $urandom; bus_gnt = 1'($urandom_range(0, 1));
      bus_rvalid = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      @(posedge clock) #1;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  // Monitor: scoreboards, hold/idle rules and post-reset output state.
  int          busy_cnt = 0, req_cnt = 0;
  logic        prev_busy = 1'b0, in_req = 1'b0, rst_prev = 1'b0;
  logic [31:0] last_rd = '0;
  bexp_t       cur_b;
  cexp_t       cur_c;

  always @(negedge clock) begin
    if (!reset) begin
      busy_cnt = 0; prev_busy = 1'b0; in_req = 1'b0; last_rd = '0; rst_prev = 1'b0;
    end else begin
      if (!rst_prev) begin
        check("rst_read_data", read_data, 32'd0);
        check("rst_ctrl", {23'd0, busy, bus_req, bus_we, bus_be, misaligned, bus_error}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
      end
      rst_prev = 1'b1;
      if (bus_req) begin
        if (!in_req) begin
          check("req_expected", 32'(bexp_q.size() != 0), 32'd1);
          if (bexp_q.size() != 0) cur_b = bexp_q.pop_front();
          in_req = 1'b1;
          req_cnt = 0;
        end
        check("bus_addr", bus_addr, cur_b.addr);
        check("bus_we", 32'(bus_we), 32'(cur_b.we));
        check("bus_be", 32'(bus_be), 32'(cur_b.be));
        check("bus_wdata", bus_wdata, cur_b.wdata);
        req_cnt++;
      end else if (in_req) begin
        check("req_cycles", 32'(req_cnt), 32'(cur_b.req));
        in_req = 1'b0;
      end
      if (prev_busy && !busy) begin
        check("done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur_c = exp_q.pop_front();
          check("read_data", read_data, cur_c.rd);
          check("misaligned", 32'(misaligned), 32'(cur_c.mis));
          check("bus_error", 32'(bus_error), 32'(cur_c.err));
          check("busy_cycles", 32'(busy_cnt), 32'(cur_c.busy));
          last_rd = cur_c.rd;
        end
        busy_cnt = 0;
      end else begin
        check("rd_hold", read_data, last_rd);
        check("flags_outside_done", {30'd0, misaligned, bus_error}, 32'd0);
      end
      if (busy) busy_cnt++;
      prev_busy = busy;
      if (end_req && !end_ack) begin
        check("sb_empty", 32'(exp_q.size() + bexp_q.size()), 32'd0);
        end_ack = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t vs limit 1000000", $time);
    $fatal(1);
  end

  initial begin
    bexp_t rb;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock) #1;

    do_access(32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'b000, 0, 0, 32'h80AA_BBCC);
    do_access(32'h0000_0202, 32'h0000_ABCD, 1'b0, 1'b1, 3'b001, 0, 0, 32'h5555_5555);
    do_access(32'h0000_0400, 32'h0, 1'b1, 1'b0, 3'b101, 0, 1, 32'h1234_F00D);
    do_access(32'h0000_0400, 32'h0, 1'b1, 1'b0, 3'b001, 0, 0, 32'h1234_F00D);

    // Reset while waiting for rvalid; rvalid during and after reset must be ignored.
    rb.addr = 32'h10; rb.we = 1'b0; rb.be = 4'hF; rb.wdata = 32'h0; rb.req = 1;
    bexp_q.push_back(rb);
    address = 32'h10; read_enable = 1'b1; format = 3'b010;
    @(posedge clock) #1;
    bus_gnt = 1'b1;
    @(posedge clock) #1;
    bus_gnt = 1'b0;
    @(posedge clock) #1;
    reset = 1'b0; read_enable = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(posedge clock) #1;
    reset = 1'b1;
    @(posedge clock) #1;
    bus_rvalid = 1'b0;
    @(posedge clock) #1;

    do_access(32'h0000_0008, 32'h0, 1'b1, 1'b0, 3'b010, 0, 0, 32'h1357_2468);
    do_access(32'h0000_0101, 32'h0, 1'b1, 1'b0, 3'b010, 0, 0, 32'hFFFF_FFFF);
    do_access(32'h0000_0300, 32'hCAFE_F00D, 1'b0, 1'b1, 3'b010, 3, 10, 32'h0);

    for (int i = 0; i < 300; i++) begin
      int k;
      idle_noise($urandom_range(0, 2));
      k = $urandom_range(1, 3);
      do_access($urandom, $urandom, k[0], k[1], 3'($urandom_range(0, 7)),
                $urandom_range(0, 3), $urandom_range(0, 5), $urandom);
    end

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Sits directly downstream of the pipeline datapath's MEM stage.
- Takes the MEM-stage data memory request: address, write data, read/write enable and funct3 format.
- Converts it into a word-aligned request/grant/response bus transaction with byte enables, lane steering and sign extension.
- Returns formatted load data and drives a `busy` stall to the hazard/control logic until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waited in WAIT for bus_rvalid before abort (1..65535).

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- address  input  32  MEM-stage byte address
- write_data  input  32  store data (rs2), right-aligned
- read_enable  input  1  load request
- write_enable  input  1  store request
- format  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- read_data  output  32  formatted load result
- busy  output  1  stall request to pipeline control
- misaligned  output  1  access misaligned, not performed
- bus_error  output  1  access aborted by timeout
- bus_req  output  1  bus request
- bus_addr  output  32  word address, bits [1:0]=00
- bus_we  output  1  1=write
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-steered store data
- bus_gnt  input  1  request accepted this cycle
- bus_rvalid  input  1  response/ack valid
- bus_rdata  input  32  read response word

Behaviour:
- Interface:
  - One clock, `clock`.
  - `reset` is synchronous and active-low: sampled on a rising clock edge while 0.
- Reset values:
  - FSM state IDLE, timeout counter 0.
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata, read_data, misaligned and bus_error all 0.
- Access detection and holding:
  - access = read_enable | write_enable.
  - If both enables are 1, the access is a write.
  - The pipeline holds all inputs stable while busy=1.
- busy (combinational): 1 when (IDLE && access), or in REQ, or in WAIT. 0 in DONE and in IDLE with no access.
- Misalignment check:
  - H/HU misaligned when address[0]=1.
  - W misaligned when address[1:0]!=00.
  - Formats 011, 110 and 111 are treated as W.
- IDLE:
  - On access and misaligned: go to DONE, set misaligned=1, drive no bus activity, set read_data=0.
  - On access and aligned: go to REQ. Register bus_addr={address[31:2],2'b00}, bus_we, bus_be and bus_wdata.
- Byte enables and write data:
  - B/BU: be = 1<<address[1:0]; wdata = byte replicated to 4 lanes.
  - H/HU: be = 0011 at offset 0, 1100 at offset 2; wdata = halfword replicated.
  - W: be = 1111; wdata = write_data.
  - For reads, bus_be is computed the same way.
- REQ:
  - bus_req=1; bus_addr, bus_we, bus_be and bus_wdata held stable.
  - On bus_gnt: go to WAIT, counter=0.
- WAIT:
  - bus_req=0.
  - On bus_rvalid: capture into read_data, then go to DONE. Loads capture the formatted bus_rdata; writes capture 0 (rvalid acts as the write ack).
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without rvalid: go to DONE, set bus_error=1, read_data=0.
- Load formatting:
  - Lane = address[1:0] (halfword lane = address[1]).
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- DONE:
  - busy=0, so the pipeline advances this cycle.
  - misaligned and bus_error are valid only in DONE and clear on leaving it.
  - Always go to IDLE next cycle. A back-to-back access therefore starts in the following IDLE.
- Latency:
  - Aligned access with gnt in the first REQ cycle and rvalid the cycle after gnt: busy=1 for 3 cycles (IDLE, REQ, WAIT), DONE on the 4th.
  - Misaligned access: busy for 1 cycle.
- read_data holds its value until the next capture.
- bus_rvalid is ignored outside WAIT, including stale responses arriving after reset.
- bus_gnt is ignored outside REQ.
- Reset mid-operation: from any state, return to IDLE with all outputs at their reset values. The outstanding bus transaction is abandoned.

Test Plan:
- LB at 0x00000103, gnt in the first REQ cycle, rvalid the next cycle with bus_rdata=0x80AABBCC:
  - bus_addr=0x100, be=1000.
  - read_data=0xFFFFFF80 in DONE; busy high exactly 3 cycles.
- SH at 0x00000202, write_data=0x0000ABCD:
  - be=1100, wdata=0xABCDABCD, bus_we=1.
  - After rvalid, DONE with misaligned=0 and bus_error=0.
- LHU at 0x00000400, bus_rdata=0x1234F00D: read_data=0x0000F00D. LH from the same word: read_data=0xFFFFF00D.
- LW at 0x00000101:
  - bus_req never asserts, busy high 1 cycle.
  - Next cycle DONE with misaligned=1 and read_data=0.
- SW with gnt delayed 3 cycles:
  - bus_req and all bus fields stay stable for 4 REQ cycles.
  - Then TIMEOUT_CYCLES=4 with no rvalid: bus_error=1 in DONE, read_data=0.
- reset=0 during WAIT:
  - Next cycle IDLE with all outputs 0.
  - A late bus_rvalid is ignored and read_data stays 0.
  - A following LW at 0x8 completes normally.
